// File: rtl/accumulator_drain_pkg.sv
// Shared constants and FSM encoding for the accumulator bank read-side drain controller.
package accumulator_drain_pkg;

  localparam int ARRAY_COL      = 4;
  localparam int ACC_WIDTH_DFLT = 32;
  localparam int ACC_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    DRN_IDLE  = 2'd0,
    DRN_DRAIN = 2'd1,
    DRN_FLUSH = 2'd2,
    DRN_DONE  = 2'd3
  } drn_state_e;

endpackage

// File: rtl/accumulator_drain.sv
// Walks a contiguous accumulator_bank range, streams each row over valid/ready,
// and optionally zeroes every row in the same cycle it is read.
module accumulator_drain
  import accumulator_drain_pkg::*;
#(
  parameter int ADDR_WIDTH = ACC_ADDR_WIDTH,
  parameter int NUM_COL    = ARRAY_COL,
  parameter int ACC_WIDTH  = ACC_WIDTH_DFLT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH:0]            num_rows,
  input  logic                           clear_en,
  output logic [ADDR_WIDTH-1:0]          bank_addr,
  output logic                           bank_wr_en,
  output logic                           bank_acc_mode,
  output logic [NUM_COL*ACC_WIDTH-1:0]   bank_wdata,
  input  logic [NUM_COL*ACC_WIDTH-1:0]   bank_rdata,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_COL*ACC_WIDTH-1:0]   m_data,
  output logic [ADDR_WIDTH-1:0]          m_row,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done
);

  drn_state_e              state;
  drn_state_e              state_nxt;
  logic [ADDR_WIDTH:0]     rows_issued;
  logic [ADDR_WIDTH:0]     num_q;
  logic                    clear_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    load;
  logic                    last_row;
  logic                    handshake;
  logic                    accept;

  assign handshake = m_valid & m_ready;
  assign accept    = (state == DRN_IDLE) & start;
  assign last_row  = ((rows_issued + {{ADDR_WIDTH{1'b0}}, 1'b1}) == num_q);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      DRN_IDLE: begin
        if (start) begin
          state_nxt = (num_rows == '0) ? DRN_DONE : DRN_DRAIN;
        end
      end
      DRN_DRAIN: begin
        load = ~m_valid | m_ready;
        if (load && last_row) begin
          state_nxt = DRN_FLUSH;
        end
      end
      DRN_FLUSH: begin
        if (handshake) begin
          state_nxt = DRN_DONE;
        end
      end
      DRN_DONE: begin
        state_nxt = DRN_IDLE;
      end
      default: begin
        state_nxt = DRN_IDLE;
      end
    endcase
  end

  // Clear writes share the read cycle; the bank captures zero on the same edge the row is registered.
  assign bank_addr     = addr_q;
  assign bank_wr_en    = load & clear_q;
  assign bank_acc_mode = 1'b0;
  assign bank_wdata    = '0;
  assign busy          = (state != DRN_IDLE);
  assign done          = (state == DRN_DONE);

  // Command capture and address walk
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DRN_IDLE;
      rows_issued <= '0;
      num_q       <= '0;
      clear_q     <= 1'b0;
      addr_q      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rows_issued <= '0;
        num_q       <= num_rows;
        clear_q     <= clear_en;
        addr_q      <= base_addr;
      end else if (load) begin
        rows_issued <= rows_issued + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if (!last_row) begin
          addr_q <= addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Output register stage: holds while stalled, refills on the same edge a beat is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      m_row   <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_last  <= last_row;
      m_data  <= bank_rdata;
      m_row   <= addr_q;
    end else if (handshake) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule
